// File: rtl/mem_rmw_sequencer_pkg.sv
// Shared encodings for the frame-buffer read-modify-write sequencer.
// Holds sweep modes, FSM states and the error counter width.
package mem_seq_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [1:0] {
        MODE_INC    = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_VERIFY = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MODIFY,
        WR_REQ,
        WR_WAIT,
        NEXT
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_rmw_sequencer_done_edge_tracker.sv
// done_edge_tracker: qualifies controller Done as low-then-high after a request,
// so a Done level left over from the previous operation never completes one.
module done_edge_tracker (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic wait_i,
    input  logic done_i,
    output logic op_complete_o
);

    logic seen_low_q, seen_low_d;

    always_comb begin
        seen_low_d = seen_low_q;
        if (req_i) begin
            seen_low_d = 1'b0;
        end else if (wait_i && !done_i) begin
            seen_low_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seen_low_q <= 1'b0;
        end else begin
            seen_low_q <= seen_low_d;
        end
    end

    assign op_complete_o = wait_i && seen_low_q && done_i;

endmodule

// File: rtl/mem_rmw_sequencer.sv
// mem_rmw_sequencer: sweeps bank rows through start/Write/Done (INC, FILL, VERIFY).
// Define MEMSEQ_TIMEOUT_EN to bound every Done wait by TIMEOUT_CYCLES.
module mem_rmw_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 4,
    parameter int BANK_W         = 2,
    parameter int NUM_ROWS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pattern,
    input  logic [BANK_W-1:0] bank,
    output logic              busy,
    output logic              finished,
    output logic [ERR_W-1:0]  err_count,
    output logic              timeout_flag,
    output logic [ADDR_W-1:0] cur_row,
    output logic [DATA_W-1:0] last_data,
    output logic [ADDR_W-1:0] mem_row,
    output logic [BANK_W-1:0] mem_bank,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_write,
    output logic              mem_start,
    input  logic              mem_done
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fin_q, fin_d;
    logic              waiting;
    logic              op_done;
    logic [ADDR_W-1:0] row_nxt;

    assign row_nxt   = row_q + 1'b1;
    assign waiting   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign mem_start = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_write = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign busy      = (state_q != IDLE);
    assign finished  = fin_q;
    assign err_count = err_q;
    assign cur_row   = row_q;
    assign mem_row   = row_q;
    assign mem_bank  = bank_q;
    assign mem_wdata = wdata_q;
    assign last_data = last_q;

    done_edge_tracker u_done (
        .clk_i        (CLOCK_50),
        .rst_n_i      (RESET_N),
        .req_i        (mem_start),
        .wait_i       (waiting),
        .done_i       (mem_done),
        .op_complete_o(op_done)
    );

`ifdef MEMSEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             tmo_hit;

    assign tmo_hit = waiting && !op_done
                  && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = tmo_q;
`else
    localparam logic [31:0] TMO_UNUSED = TIMEOUT_CYCLES;
    logic unused_tmo;
    assign unused_tmo   = ^TMO_UNUSED;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        last_d    = last_q;
        wdata_d   = wdata_q;
        bank_d    = bank_q;
        row_d     = row_q;
        err_d     = err_q;
        fin_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (mode != MODE_RSVD)) begin
                    mode_d    = mode_e'(mode);
                    pattern_d = pattern;
                    bank_d    = bank;
                    err_d     = '0;
                    row_d     = '0;
                    if (mode == MODE_FILL) begin
                        wdata_d = pattern;
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (op_done) begin
                    last_d  = mem_rdata;
                    state_d = MODIFY;
                end
            end
            MODIFY: begin
                if (mode_q == MODE_INC) begin
                    wdata_d = last_q + DATA_W'(row_q) + DATA_W'(1);
                    state_d = WR_REQ;
                end else begin
                    if (last_q != (pattern_q ^ DATA_W'(row_q))) begin
                        err_d = sat_inc(err_q);
                    end
                    state_d = NEXT;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (op_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (row_q == LAST_ROW) begin
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    row_d = row_nxt;
                    if (mode_q == MODE_FILL) begin
                        wdata_d = pattern_q ^ DATA_W'(row_nxt);
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEMSEQ_TIMEOUT_EN
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (mem_start) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
        // An expired wait abandons the whole sweep, not just the row
        if (tmo_hit) begin
            state_d = IDLE;
            fin_d   = 1'b1;
            tmo_d   = 1'b1;
            err_d   = sat_inc(err_q);
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            mode_q    <= MODE_INC;
            pattern_q <= '0;
            last_q    <= '0;
            wdata_q   <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            err_q     <= '0;
            fin_q     <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            last_q    <= last_d;
            wdata_q   <= wdata_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            err_q     <= err_d;
            fin_q     <= fin_d;
`ifdef MEMSEQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_rmw_sequencer.sv
// Bench for mem_rmw_sequencer: table sweeps, Done/start/reset corner sequences,
// and randomized sweeps against a sweep-level memory and request model.
`timescale 1ns/1ps
module tb_mem_rmw_sequencer;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int BW  = 2;
    localparam int NR  = 16;
    localparam int TMO = 8;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'd0;
    logic [DW-1:0] pattern  = '0;
    logic [BW-1:0] bank     = '0;
    logic          busy, finished, timeout_flag, mem_write, mem_start;
    logic [15:0]   err_count;
    logic [AW-1:0] cur_row, mem_row;
    logic [DW-1:0] last_data, mem_wdata;
    logic [BW-1:0] mem_bank;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    mem_rmw_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .BANK_W(BW),
        .NUM_ROWS(NR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .mode(mode), .pattern(pattern), .bank(bank),
        .busy(busy), .finished(finished), .err_count(err_count),
        .timeout_flag(timeout_flag), .cur_row(cur_row),
        .last_data(last_data), .mem_row(mem_row), .mem_bank(mem_bank),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_start(mem_start), .mem_done(mem_done)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] row;
        logic [BW-1:0] bk;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic [BW-1:0] bk;
        logic [AW-1:0] row;
        logic [DW-1:0] data;
    } bd_t;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] pat;
        logic [1:0]  bk;
        int          corrupt;
        int          err;
    } vec_t;

    op_t           exp_ops[$];
    bd_t           bd_q[$];
    logic [DW-1:0] mem [4][16] = '{default: '0};

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Memory controller model: Done falls after a request, rises after a delay
    bit   pending    = 1'b0;
    bit   never_done = 1'b0;
    int   hold_cfg   = 0;
    int   hold       = 0;
    int   dly        = 0;
    op_t  cur;
    bd_t  bd;

    always @(posedge CLOCK_50) begin
        while (bd_q.size() > 0) begin
            bd = bd_q.pop_front();
            mem[bd.bk][bd.row] = bd.data;
        end
        if (mem_start) begin
            pending  <= 1'b1;
            cur.wr   <= mem_write;
            cur.row  <= mem_row;
            cur.bk   <= mem_bank;
            cur.data <= mem_wdata;
            hold     <= hold_cfg;
            dly      <= $urandom_range(1, 4);
            if (hold_cfg == 0) mem_done <= 1'b0;
        end else if (pending) begin
            if (hold > 0) begin
                hold <= hold - 1;
                if (hold == 1) mem_done <= 1'b0;
            end else if (!never_done) begin
                if (dly > 1) begin
                    dly <= dly - 1;
                end else begin
                    mem_done <= 1'b1;
                    pending  <= 1'b0;
                    if (cur.wr) mem[cur.bk][cur.row] = cur.data;
                    else mem_rdata <= mem[cur.bk][cur.row];
                end
            end
        end
    end

    // Request monitor against the expected operation queue
    int  fin_count = 0;
    op_t mon_e;

    always @(negedge CLOCK_50) begin
        if (finished) fin_count++;
        if (RESET_N && mem_start) begin
            check("req_while_pending", 64'(pending), 64'(0));
            if (exp_ops.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got row %0d write %0b, required none",
                         mem_row, mem_write);
            end else begin
                mon_e = exp_ops.pop_front();
                check("req_write", 64'(mem_write), 64'(mon_e.wr));
                check("req_row", 64'(mem_row), 64'(mon_e.row));
                check("req_bank", 64'(mem_bank), 64'(mon_e.bk));
                if (mon_e.wr) check("req_wdata", 64'(mem_wdata), 64'(mon_e.data));
            end
        end
    end

    logic [DW-1:0] m_snap [NR];
    logic [DW-1:0] m_fin  [NR];
    int            m_err;

    task automatic put(input logic [BW-1:0] bk, input int row, input logic [DW-1:0] d);
        bd_t b;
        b.bk   = bk;
        b.row  = AW'(row);
        b.data = d;
        bd_q.push_back(b);
    endtask

    task automatic build_model(input logic [1:0] m, input logic [DW-1:0] pat,
                               input logic [BW-1:0] bk);
        op_t           o;
        logic [DW-1:0] want;
        m_err = 0;
        for (int r = 0; r < NR; r++) begin
            m_snap[r] = mem[bk][r];
            m_fin[r]  = m_snap[r];
            want      = pat ^ DW'(r);
            o.row     = AW'(r);
            o.bk      = bk;
            o.data    = '0;
            if (m != 2'd1) begin
                o.wr = 1'b0;
                exp_ops.push_back(o);
            end
            if (m == 2'd0) begin
                m_fin[r] = m_snap[r] + DW'(r) + DW'(1);
                o.wr     = 1'b1;
                o.data   = m_fin[r];
                exp_ops.push_back(o);
            end else if (m == 2'd1) begin
                m_fin[r] = want;
                o.wr     = 1'b1;
                o.data   = want;
                exp_ops.push_back(o);
            end else if (m_snap[r] != want) begin
                m_err++;
            end
        end
    endtask

    task automatic run_sweep(input logic [1:0] m, input logic [DW-1:0] pat,
                             input logic [BW-1:0] bk, input int exp_err,
                             input int poke);
        bit done = 1'b0;
        int want_err;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        build_model(m, pat, bk);
        want_err  = (exp_err >= 0) ? exp_err : m_err;
        fin_count = 0;
        mode      = m;
        pattern   = pat;
        bank      = bk;
        start     = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("row_after_start", 64'(cur_row), 64'(0));
        for (int i = 0; i < 3000 && !done; i++) begin
            if (i == poke) begin
                start   = 1'b1;
                mode    = 2'd1;
                pattern = ~pat;
                bank    = ~bk;
            end else begin
                start = 1'b0;
            end
            @(negedge CLOCK_50);
            if (i == poke) check("busy_ignored_start", 64'(busy), 64'(1));
            if (finished) done = 1'b1;
        end
        start = 1'b0;
        check("sweep_finished", 64'(done), 64'(1));
        check("busy_at_finish", 64'(busy), 64'(0));
        check("err_count", 64'(err_count), 64'(want_err));
        check("row_at_finish", 64'(cur_row), 64'(NR - 1));
        check("timeout_flag_clear", 64'(timeout_flag), 64'(0));
        if (m != 2'd1) check("last_data", 64'(last_data), 64'(m_snap[NR-1]));
        @(negedge CLOCK_50);
        check("finished_one_cycle", 64'(finished), 64'(0));
        check("finished_count", 64'(fin_count), 64'(1));
        check("ops_drained", 64'(exp_ops.size()), 64'(0));
        exp_ops.delete();
        for (int r = 0; r < NR; r++) begin
            check("mem_after_sweep", 64'(mem[bk][r]), 64'(m_fin[r]));
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, finished, err_count, timeout_flag, cur_row, last_data,
                    mem_row, mem_bank, mem_wdata, mem_write, mem_start});
    endfunction

    vec_t vecs[6];

    initial begin
        bit            seen;
        logic [1:0]    rm;
        logic [DW-1:0] rp;
        logic [BW-1:0] rb;

        vecs[0] = '{2'd0, 16'h0000, 2'd0, -1, 0};
        vecs[1] = '{2'd0, 16'h0000, 2'd0, -1, 0};
        vecs[2] = '{2'd1, 16'hA5A0, 2'd1, -1, 0};
        vecs[3] = '{2'd2, 16'hA5A0, 2'd1, -1, 0};
        vecs[4] = '{2'd2, 16'hA5A0, 2'd1,  3, 1};
        vecs[5] = '{2'd2, 16'h1234, 2'd1, -1, 16};

        repeat (3) @(negedge CLOCK_50);
        check("reset_outputs", outs(), 64'(0));
        RESET_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].corrupt >= 0) begin
                put(vecs[i].bk, vecs[i].corrupt,
                    vecs[i].pat ^ DW'(vecs[i].corrupt) ^ 16'h0100);
            end
            run_sweep(vecs[i].m, vecs[i].pat, vecs[i].bk, vecs[i].err, -1);
            if (i == 0) begin
                for (int r = 0; r < NR; r++) check("inc1_row", 64'(mem[0][r]), 64'(r + 1));
            end
            if (i == 1) begin
                for (int r = 0; r < NR; r++) check("inc2_row", 64'(mem[0][r]), 64'(2 * r + 2));
            end
        end

        // Done held high across the next request
        hold_cfg = 3;
        run_sweep(2'd0, 16'h0000, 2'd2, 0, -1);
        hold_cfg = 0;

        // start while busy, then reserved mode while idle
        run_sweep(2'd1, 16'h0F0F, 2'd3, 0, 10);
        mode  = 2'd3;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        check("rsvd_busy", 64'(busy), 64'(0));
        check("rsvd_row", 64'(cur_row), 64'(NR - 1));

        for (int k = 0; k < 8; k++) begin
            rm       = 2'($urandom_range(0, 2));
            rp       = DW'($urandom);
            rb       = BW'($urandom_range(0, 3));
            hold_cfg = $urandom_range(0, 2);
            for (int r = 0; r < NR; r++) begin
                if (rm == 2'd2 && $urandom_range(0, 3) != 0) put(rb, r, rp ^ DW'(r));
                else put(rb, r, DW'($urandom));
            end
            run_sweep(rm, rp, rb, -1, -1);
        end
        hold_cfg = 0;

        // Reset while waiting on the row-5 write
        repeat (2) @(negedge CLOCK_50);
        build_model(2'd0, 16'h0000, 2'd0);
        fin_count = 0;
        mode      = 2'd0;
        bank      = 2'd0;
        start     = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (mem_start && mem_write && mem_row == 4'd5) seen = 1'b1;
        end
        check("row5_write_seen", 64'(seen), 64'(1));
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        check("reset_mid_sweep", outs(), 64'(0));
        RESET_N = 1'b1;
        exp_ops.delete();
        repeat (20) @(negedge CLOCK_50);
        check("reset_no_finish", 64'(fin_count), 64'(0));
        check("reset_idle", 64'(busy), 64'(0));

`ifdef MEMSEQ_TIMEOUT_EN
        begin
            op_t o;
            bit  done = 1'b0;
            o.wr       = 1'b0;
            o.row      = '0;
            o.bk       = '0;
            o.data     = '0;
            exp_ops.push_back(o);
            never_done = 1'b1;
            fin_count  = 0;
            mode       = 2'd0;
            start      = 1'b1;
            @(negedge CLOCK_50);
            start = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                @(negedge CLOCK_50);
                if (finished) done = 1'b1;
            end
            check("tmo_finished", 64'(done), 64'(1));
            check("tmo_flag", 64'(timeout_flag), 64'(1));
            check("tmo_err", 64'(err_count), 64'(1));
            check("tmo_busy", 64'(busy), 64'(0));
            @(negedge CLOCK_50);
            check("tmo_fin_count", 64'(fin_count), 64'(1));
            check("tmo_flag_sticky", 64'(timeout_flag), 64'(1));
            never_done = 1'b0;
            repeat (10) @(negedge CLOCK_50);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
